// File: rtl/rec_play_engine.sv
// rec_play_engine: two-slot multi-channel audio record/playback engine between codec strobe and RAM wrapper.
// Ports: clk/reset (async active-low); mode/pause/clear/rewind/slot controls; sample_strobe + audio_in frame;
// audio_out/audio_out_valid played frame; ram_* wrapper handshake; state, rec_end, full, overrun, done status.
// Optional build macro REC_PLAY_LOOP_EN: end-of-recording strobe restarts playback at the slot base instead of pulsing done.
module rec_play_engine #(
  parameter int SAMPLE_W = 16,
  parameter int ADDR_W = 26,
  parameter int CHANNELS = 2,
  parameter logic [ADDR_W-1:0] SLOT0_BASE = 26'h0000000,
  parameter logic [ADDR_W-1:0] SLOT1_BASE = 26'h0C00000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   mode,
  input  logic                         pause,
  input  logic                         clear,
  input  logic                         rewind,
  input  logic                         slot,
  input  logic                         sample_strobe,
  input  logic [CHANNELS*SAMPLE_W-1:0] audio_in,
  output logic [CHANNELS*SAMPLE_W-1:0] audio_out,
  output logic                         audio_out_valid,
  input  logic                         ram_rdy,
  input  logic                         ram_rd_pres,
  input  logic [SAMPLE_W-1:0]          ram_rd_data,
  input  logic [ADDR_W-1:0]            ram_max_addr,
  output logic [ADDR_W-1:0]            ram_addr,
  output logic [SAMPLE_W-1:0]          ram_wdata,
  output logic                         ram_we,
  output logic                         ram_rd_req,
  output logic                         ram_rd_ack,
  output logic [2:0]                   state,
  output logic [ADDR_W-1:0]            rec_end,
  output logic                         full,
  output logic                         overrun,
  output logic                         done
);
  localparam int FW = CHANNELS * SAMPLE_W;
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  typedef enum logic [2:0] {IDLE, REC_WAIT, REC_WRITE, PLAY_WAIT, PLAY_REQ, PLAY_DATA, PLAY_OUT} st_t;
  st_t st, st_n;
  logic [ADDR_W-1:0] ptr, end0, end1, base_q, region_end, idle_ptr;
  logic [CW-1:0] ch;
  logic slot_q, got, last_ch, room, play_go, at_end, empty, busy;
  logic [FW-1:0] stage, frame;
  assign base_q = slot_q ? SLOT1_BASE : SLOT0_BASE;
  assign region_end = slot_q ? ram_max_addr : SLOT1_BASE - 1'b1;
  assign idle_ptr = rewind ? (slot ? SLOT1_BASE : SLOT0_BASE) : ptr;
  assign rec_end = slot_q ? end1 : end0;
  assign last_ch = ch == CW'(CHANNELS - 1);
  assign room = ptr <= region_end;
  assign at_end = ptr == rec_end;
  assign empty = rec_end == base_q;
  assign play_go = st == PLAY_WAIT && mode == 2'b10 && sample_strobe && !pause;
  assign busy = st == REC_WRITE || st == PLAY_REQ || st == PLAY_DATA || st == PLAY_OUT;
  assign state = st;
  assign audio_out_valid = st == PLAY_OUT;
  assign ram_addr = (ram_we || ram_rd_req) ? ptr : '0;
  assign ram_wdata = ram_we ? stage[ch*SAMPLE_W +: SAMPLE_W] : '0;
  always_comb begin
    st_n = st;
    ram_we = 1'b0;
    ram_rd_req = 1'b0;
    ram_rd_ack = 1'b0;
    done = 1'b0;
    case (st)
      IDLE: st_n = mode == 2'b01 ? REC_WAIT : mode == 2'b10 ? PLAY_WAIT : IDLE;
      REC_WAIT: st_n = mode != 2'b01 ? IDLE : sample_strobe ? REC_WRITE : REC_WAIT;
      REC_WRITE: begin
        ram_we = room && ram_rdy;
        st_n = (!room || (ram_rdy && last_ch)) ? REC_WAIT : REC_WRITE;
      end
      PLAY_WAIT: begin
        if (mode != 2'b10) st_n = IDLE;
        else if (play_go && !at_end) st_n = PLAY_REQ;
`ifdef REC_PLAY_LOOP_EN
        else if (play_go && !empty) st_n = PLAY_REQ;
`else
        else if (play_go) begin
          done = 1'b1;
          st_n = IDLE;
        end
`endif
      end
      PLAY_REQ: begin
        ram_rd_req = ram_rdy;
        st_n = ram_rdy ? PLAY_DATA : PLAY_REQ;
      end
      PLAY_DATA: begin
        ram_rd_ack = got;
        st_n = !got ? PLAY_DATA : last_ch ? PLAY_OUT : PLAY_REQ;
      end
      PLAY_OUT: st_n = PLAY_WAIT;
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= IDLE;
      ptr <= SLOT0_BASE;
      end0 <= SLOT0_BASE;
      end1 <= SLOT1_BASE;
      slot_q <= 1'b0;
      ch <= '0;
      got <= 1'b0;
      stage <= '0;
      frame <= '0;
      audio_out <= '0;
      full <= 1'b0;
      overrun <= 1'b0;
    end else begin
      st <= st_n;
      if (sample_strobe && busy) overrun <= 1'b1;
      if (st == IDLE) begin
        slot_q <= slot;
        ptr <= idle_ptr;
        if (slot != slot_q) full <= 1'b0;
        // Starting a recording truncates the slot at the current pointer.
        if (mode == 2'b01 && slot) end1 <= idle_ptr;
        if (mode == 2'b01 && !slot) end0 <= idle_ptr;
      end
      if (st == REC_WAIT && mode == 2'b01 && sample_strobe) begin
        stage <= clear ? '0 : audio_in;
        ch <= '0;
      end
      if (st == REC_WRITE && !room) full <= 1'b1;
      if (ram_we) begin
        ptr <= ptr + 1'b1;
        ch <= ch + 1'b1;
        if (slot_q) end1 <= ptr + 1'b1;
        else end0 <= ptr + 1'b1;
      end
      if (play_go) begin
        ch <= '0;
`ifdef REC_PLAY_LOOP_EN
        if (at_end) ptr <= base_q;
`endif
      end
      // got splits PLAY_DATA into capture and acknowledge cycles.
      if (st == PLAY_DATA && !got && ram_rd_pres) begin
        frame[ch*SAMPLE_W +: SAMPLE_W] <= ram_rd_data;
        got <= 1'b1;
      end
      if (ram_rd_ack) begin
        got <= 1'b0;
        ptr <= ptr + 1'b1;
        ch <= ch + 1'b1;
        if (last_ch) audio_out <= frame;
      end
      if (rewind) begin
        full <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rec_play_engine.sv
// tb_rec_play_engine: directed bench with a spec-level model and a RAM wrapper responder.
module tb_rec_play_engine;
  localparam int SW = 16;
  localparam int AW = 26;
  localparam int CH = 2;
  localparam logic [AW-1:0] B0 = 26'h0000000;
  localparam logic [AW-1:0] B1 = 26'h0C00000;
  logic clk = 0, reset = 0;
  logic [1:0] mode = 0;
  logic pause = 0, clear = 0, rewind = 0, slot = 0, sample_strobe = 0;
  logic [CH*SW-1:0] audio_in = 0, audio_out;
  logic audio_out_valid, ram_rdy = 1, ram_rd_pres = 0;
  logic [SW-1:0] ram_rd_data = 0, ram_wdata;
  logic [AW-1:0] ram_max_addr = B1 + 1, ram_addr, rec_end;
  logic ram_we, ram_rd_req, ram_rd_ack, full, overrun, done;
  logic [2:0] state;
  rec_play_engine #(.SAMPLE_W(SW), .ADDR_W(AW), .CHANNELS(CH), .SLOT0_BASE(B0), .SLOT1_BASE(B1)) dut (
    .clk(clk), .reset(reset), .mode(mode), .pause(pause), .clear(clear), .rewind(rewind), .slot(slot),
    .sample_strobe(sample_strobe), .audio_in(audio_in), .audio_out(audio_out), .audio_out_valid(audio_out_valid),
    .ram_rdy(ram_rdy), .ram_rd_pres(ram_rd_pres), .ram_rd_data(ram_rd_data), .ram_max_addr(ram_max_addr),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rd_req(ram_rd_req), .ram_rd_ack(ram_rd_ack),
    .state(state), .rec_end(rec_end), .full(full), .overrun(overrun), .done(done));
  always #5 clk = ~clk;
  int total = 0, bad = 0, nwe = 0, nreq = 0, nack = 0, nval = 0, cyc = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  // spec-level model: pointer, per-slot end marks, memory image, expected traffic
  logic [SW-1:0] m_mem [int];
  logic [AW-1:0] m_ptr = B0;
  logic [AW-1:0] m_end [2] = '{B0, B1};
  logic m_slot = 0, m_full = 0;
  logic [AW+SW-1:0] wq [$];
  logic [CH*SW-1:0] fq [$];
  function automatic logic [AW-1:0] region_end(input logic s);
    return s ? ram_max_addr : B1 - 1;
  endfunction
  task automatic model_record(input logic [CH*SW-1:0] f);
    for (int c = 0; c < CH; c++) begin
      if (m_ptr > region_end(m_slot)) begin
        m_full = 1;
        break;
      end
      wq.push_back({m_ptr, f[c*SW +: SW]});
      m_mem[int'(m_ptr)] = f[c*SW +: SW];
      m_ptr++;
      m_end[m_slot] = m_ptr;
    end
  endtask
  task automatic model_play();
    logic [CH*SW-1:0] f;
    for (int c = 0; c < CH; c++) begin
      f[c*SW +: SW] = m_mem[int'(m_ptr)];
      m_ptr++;
    end
    fq.push_back(f);
  endtask
  // RAM wrapper: stores writes, answers each read 4 cycles after the request
  typedef struct {int due; logic [SW-1:0] d;} pend_t;
  logic [SW-1:0] ram [int];
  pend_t pq [$];
  always @(negedge clk) begin
    if (ram_we) ram[int'(ram_addr)] = ram_wdata;
    if (ram_rd_req) pq.push_back('{cyc + 4, ram.exists(int'(ram_addr)) ? ram[int'(ram_addr)] : 16'hDEAD});
  end
  always @(posedge clk) begin
    cyc++;
    #1;
    ram_rd_pres = 0;
    if (pq.size() > 0 && pq[0].due == cyc) begin
      ram_rd_pres = 1;
      ram_rd_data = pq[0].d;
      void'(pq.pop_front());
    end
  end
  always @(negedge clk) if (reset) begin
    if (ram_we) begin
      nwe++;
      if (wq.size() == 0) chk("extra_we", 1, 0);
      else chk("we_addr_data", {ram_addr, ram_wdata}, wq.pop_front());
    end
    if (ram_rd_req) nreq++;
    if (ram_rd_ack) nack++;
    if (audio_out_valid) begin
      nval++;
      if (fq.size() == 0) chk("extra_valid", 1, 0);
      else chk("frame", audio_out, fq.pop_front());
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_strobe();
    sample_strobe = 1;
    tick();
    sample_strobe = 0;
  endtask
  task automatic wait_writes();
    for (int i = 0; i < 40 && wq.size() > 0; i++) tick();
    chk("write_timeout", wq.size(), 0);
    tick();
  endtask
  task automatic wait_frames();
    for (int i = 0; i < 60 && fq.size() > 0; i++) tick();
    chk("frame_timeout", fq.size(), 0);
  endtask
  task automatic idle_rewind(input logic s);
    mode = 0;
    tick();
    slot = s;
    rewind = 1;
    tick();
    rewind = 0;
    m_slot = s;
    m_ptr = s ? B1 : B0;
    m_full = 0;
  endtask
  task automatic start(input logic [1:0] m);
    mode = m;
    tick();
    if (m == 2'b01) m_end[m_slot] = m_ptr;
  endtask
  initial begin
    logic [CH*SW-1:0] held;
    int r0;
    repeat (2) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_outs", {audio_out, audio_out_valid, ram_addr, ram_wdata, ram_we, ram_rd_req, ram_rd_ack, rec_end, full, overrun, done}, 0);
    @(posedge clk);
    #1 reset = 1;
    start(2'b01);
    chk("rec_wait", state, 1);
    audio_in = 32'h0002_0001;
    model_record(audio_in);
    pulse_strobe();
    @(negedge clk);
    chk("first_we", {ram_we, ram_addr, ram_wdata}, {1'b1, 26'd0, 16'd1});
    @(posedge clk);
    #1;
    wait_writes();
    audio_in = 32'h0004_0003;
    model_record(audio_in);
    pulse_strobe();
    ram_rdy = 0;
    @(negedge clk);
    chk("stall_no_we", ram_we, 0);
    @(posedge clk);
    #1;
    tick();
    ram_rdy = 1;
    wait_writes();
    audio_in = 32'h0006_0005;
    model_record(audio_in);
    pulse_strobe();
    wait_writes();
    chk("rec_end_6", rec_end, 6);
    chk("rec_end_model", rec_end, m_end[0]);
    chk("we_count", nwe, 6);
    chk("back_rec_wait", state, 1);
    idle_rewind(0);
    start(2'b10);
    for (int k = 0; k < 3; k++) begin
      model_play();
      pulse_strobe();
      if (k == 0) begin
        @(negedge clk);
        chk("first_req", {ram_rd_req, ram_addr}, {1'b1, 26'd0});
        @(posedge clk);
        #1;
      end
      wait_frames();
    end
    chk("play_last", audio_out, 32'h0006_0005);
    chk("valid_count", nval, 3);
    chk("ack_count", nack, 6);
    chk("req_count", nreq, 6);
`ifdef REC_PLAY_LOOP_EN
    m_ptr = B0;
    model_play();
    pulse_strobe();
    wait_frames();
    chk("loop_frame", audio_out, 32'h0002_0001);
`else
    sample_strobe = 1;
    @(negedge clk);
    chk("done_pulse", done, 1);
    @(posedge clk);
    #1 sample_strobe = 0;
    chk("done_idle", state, 0);
    chk("done_held", audio_out, 32'h0006_0005);
    chk("done_no_req", nreq, 6);
`endif
    idle_rewind(0);
    start(2'b10);
    held = audio_out;
    r0 = nreq;
    pause = 1;
    pulse_strobe();
    repeat (8) tick();
    chk("pause_no_req", nreq, r0);
    chk("pause_held", audio_out, held);
    pause = 0;
    model_play();
    pulse_strobe();
    tick();
    pulse_strobe();
    chk("overrun_set", overrun, 1);
    wait_frames();
    chk("overrun_sticky", overrun, 1);
    chk("replay_first", audio_out, 32'h0002_0001);
    idle_rewind(1);
    chk("overrun_clr", overrun, 0);
    clear = 1;
    start(2'b01);
    audio_in = 32'hAAAA_5555;
    model_record('0);
    pulse_strobe();
    wait_writes();
    model_record('0);
    pulse_strobe();
    repeat (4) tick();
    chk("full_set", full, 1);
    chk("full_model", full, m_full);
    chk("slot1_end", rec_end, B1 + 2);
    chk("slot1_we_count", nwe, 8);
    clear = 0;
    mode = 0;
    tick();
    slot = 0;
    tick();
    chk("full_slot_clr", full, 0);
    chk("slot0_end", rec_end, 6);
    rewind = 1;
    tick();
    rewind = 0;
    m_ptr = B0;
    start(2'b01);
    audio_in = 32'h0BEE_0AAA;
    wq.push_back({B0, 16'h0AAA});
    pulse_strobe();
    @(negedge clk);
    @(posedge clk);
    #1 reset = 0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_outs", {audio_out, audio_out_valid, ram_addr, ram_wdata, ram_we, ram_rd_req, ram_rd_ack, rec_end, full, overrun, done}, 0);
    repeat (3) @(negedge clk);
    chk("arst_quiet", {ram_we, ram_rd_req, ram_rd_ack}, 0);
    @(posedge clk);
    #1 reset = 1;
    m_ptr = B0;
    m_end = '{B0, B1};
    m_slot = 0;
    start(2'b01);
    audio_in = 32'h0022_0011;
    model_record(audio_in);
    pulse_strobe();
    wait_writes();
    chk("post_rst_end", rec_end, 2);
    chk("wq_empty", wq.size(), 0);
    chk("fq_empty", fq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
